// File: rtl/cla_pkg.sv
// Shared definitions for the digit-serial carry-lookahead adder.
//   state_t   : control FSM states
//   cnt_width : group-counter width, never less than one bit
package cla_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Bits needed to count n groups; a single-group adder still keeps a 1-bit counter.
   function automatic int unsigned cnt_width(input int unsigned n);
      if (n <= 1) return 1;
      return $clog2(n);
   endfunction

endpackage

// File: rtl/cla_group_unit.sv
// Combinational GROUP-bit parallel-lookahead adder slice.
//   a, b   : slice operands
//   cin    : slice carry-in
//   sum    : slice sum
//   cout   : carry out of the slice MSB
//   c_msb  : carry into the slice MSB
//   grp_g  : group generate (carry out assuming cin=0)
//   grp_p  : group propagate (all bits propagate)
module cla_group_unit #(
   parameter int unsigned GROUP = 4
) (
   input  logic [GROUP-1:0] a,
   input  logic [GROUP-1:0] b,
   input  logic             cin,
   output logic [GROUP-1:0] sum,
   output logic             cout,
   output logic             c_msb,
   output logic             grp_g,
   output logic             grp_p
);

   logic [GROUP-1:0] g;
   logic [GROUP-1:0] p;
   logic [GROUP:0]   c;
   logic [GROUP:0]   gc;   // gc[0]=cin, gc[k+1]=g[k]: generate terms incl. carry-in
   logic [GROUP-1:0] gterms;

   assign g  = a & b;
   assign p  = a ^ b;
   assign gc = {g, cin};
   assign c[0] = cin;

   // Each carry is a flat sum of products over G/P and cin; no carry feeds another.
   for (genvar i = 0; i < GROUP; i++) begin : g_carry
      logic [i+1:0] terms;
      for (genvar j = 0; j <= i + 1; j++) begin : g_term
         if (j <= i) begin : g_prop
            assign terms[j] = gc[j] & (&p[i:j]);
         end else begin : g_gen
            assign terms[j] = gc[j];
         end
      end
      assign c[i+1] = |terms;
   end

   // Group generate: carry out of the slice with a zero carry-in.
   for (genvar k = 0; k < GROUP; k++) begin : g_grp
      if (k < GROUP - 1) begin : g_prop
         assign gterms[k] = g[k] & (&p[GROUP-1:k+1]);
      end else begin : g_top
         assign gterms[k] = g[k];
      end
   end

   assign grp_g = |gterms;
   assign grp_p = &p;
   assign sum   = p ^ c[GROUP-1:0];
   assign cout  = c[GROUP];
   assign c_msb = c[GROUP-1];

endmodule

// File: rtl/digit_serial_cla_adder.sv
// Digit-serial add/subtract: WIDTH-bit operands processed GROUP bits per clock
// through one lookahead slice, with a registered carry between groups.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (ready only while idle)
//   in_a, in_b           : operands
//   in_cin, in_sub       : carry-in; sub=1 inverts B (drive cin=1 for A-B)
//   out_valid / out_ready: result handshake, result held under backpressure
//   out_sum, out_cout    : result and carry out of the MSB
//   out_ovf              : signed overflow (carry into MSB ^ carry out of MSB)
//   busy                 : operation in progress or result pending
module digit_serial_cla_adder
   import cla_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned GROUP = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             busy
);

   localparam int unsigned NGROUPS = WIDTH / GROUP;
   localparam int unsigned CW      = cnt_width(NGROUPS);

   if ((GROUP < 1) || (WIDTH < GROUP) || ((WIDTH % GROUP) != 0)) begin : g_bad_params
      $error("digit_serial_cla_adder: WIDTH must be a non-zero multiple of GROUP");
   end

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] sum_q;
   logic             carry_q;

   logic [WIDTH-1:0] a_nxt;
   logic [WIDTH-1:0] b_nxt;
   logic [WIDTH-1:0] sum_nxt;
   logic [GROUP-1:0] s_sum;
   logic             s_cout;
   logic             s_cmsb;
   logic             s_g;
   logic             s_p;
   logic             last;

   // Lowest group of the shifting operand registers is always the active slice.
   cla_group_unit #(
      .GROUP (GROUP)
   ) u_group (
      .a     (a_q[GROUP-1:0]),
      .b     (b_q[GROUP-1:0]),
      .cin   (carry_q),
      .sum   (s_sum),
      .cout  (s_cout),
      .c_msb (s_cmsb),
      .grp_g (s_g),
      .grp_p (s_p)
   );

   // Operands shift right one group per cycle; slice sums enter from the top,
   // so after NGROUPS steps group k sits at bits [k*GROUP +: GROUP].
   if (NGROUPS > 1) begin : g_multi
      assign a_nxt   = {{GROUP{1'b0}}, a_q[WIDTH-1:GROUP]};
      assign b_nxt   = {{GROUP{1'b0}}, b_q[WIDTH-1:GROUP]};
      assign sum_nxt = {s_sum, sum_q[WIDTH-1:GROUP]};
   end else begin : g_single
      assign a_nxt   = '0;
      assign b_nxt   = '0;
      assign sum_nxt = s_sum;
   end

   assign last    = (cnt == CW'(NGROUPS - 1));
   assign out_sum = sum_q;

   // Control FSM with the datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         a_q       <= '0;
         b_q       <= '0;
         sum_q     <= '0;
         carry_q   <= 1'b0;
         out_valid <= 1'b0;
         out_cout  <= 1'b0;
         out_ovf   <= 1'b0;
         busy      <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q      <= in_a;
                  b_q      <= in_b ^ {WIDTH{in_sub}};
                  carry_q  <= in_cin;
                  cnt      <= '0;
                  busy     <= 1'b1;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               a_q     <= a_nxt;
               b_q     <= b_nxt;
               sum_q   <= sum_nxt;
               // Group-level lookahead: same value as the slice carry-out.
               carry_q <= s_g | (s_p & carry_q);
               cnt     <= cnt + CW'(1);
               if (last) begin
                  out_cout  <= s_cout;
                  out_ovf   <= s_cmsb ^ s_cout;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               busy      <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_digit_serial_cla_adder.sv
// Directed bench: 8-bit/4-group instance for function, backpressure and reset;
// two 32-bit instances (GROUP=4 and GROUP=32) sharing inputs for latency.
module tb_digit_serial_cla_adder;

   logic clk;
   logic rst_n;

   // 8-bit, GROUP=4
   logic       iv8, ir8, cin8, sub8, ov8, or8, cout8, ovf8, busy8;
   logic [7:0] a8, b8, sum8;

   // 32-bit instances sharing their input side
   logic        iv32, cin32, sub32, or32;
   logic [31:0] a32, b32;
   logic        irn, ovn, coutn, ovfn, busyn;
   logic        irw, ovw, coutw, ovfw, busyw;
   logic [31:0] sumn, sumw;

   int checks;
   int failures;

   digit_serial_cla_adder #(.WIDTH(8), .GROUP(4)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
      .in_a(a8), .in_b(b8), .in_cin(cin8), .in_sub(sub8),
      .out_valid(ov8), .out_ready(or8), .out_sum(sum8),
      .out_cout(cout8), .out_ovf(ovf8), .busy(busy8)
   );

   digit_serial_cla_adder #(.WIDTH(32), .GROUP(4)) dutn (
      .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(irn),
      .in_a(a32), .in_b(b32), .in_cin(cin32), .in_sub(sub32),
      .out_valid(ovn), .out_ready(or32), .out_sum(sumn),
      .out_cout(coutn), .out_ovf(ovfn), .busy(busyn)
   );

   digit_serial_cla_adder #(.WIDTH(32), .GROUP(32)) dutw (
      .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(irw),
      .in_a(a32), .in_b(b32), .in_cin(cin32), .in_sub(sub32),
      .out_valid(ovw), .out_ready(or32), .out_sum(sumw),
      .out_cout(coutw), .out_ovf(ovfw), .busy(busyw)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one 8-bit operation and wait (bounded) for its result.
   task automatic op8(input logic [7:0] a, input logic [7:0] b,
                      input logic cin, input logic sub, output int lat);
      @(negedge clk);
      a8 = a; b8 = b; cin8 = cin; sub8 = sub; iv8 = 1'b1;
      @(posedge clk);
      #1;
      iv8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; sub8 = 1'b0;
      lat = 0;
      while (lat < 40) begin
         @(posedge clk);
         #1;
         lat = lat + 1;
         if (ov8) break;
      end
   endtask

   task automatic release8();
      @(negedge clk);
      or8 = 1'b1;
      @(posedge clk);
      #1;
      or8 = 1'b0;
   endtask

   task automatic test_reset();
      checks++; if (ir8 !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", ir8); end
      checks++; if (ov8 !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", ov8); end
      checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy8); end
      checks++; if ({sum8, cout8, ovf8} !== 10'h000) begin failures++; $display("FAIL reset_outputs got=%h/%b/%b exp=00/0/0", sum8, cout8, ovf8); end
   endtask

   task automatic test_add();
      int lat;
      op8(8'h3C, 8'h45, 1'b0, 1'b0, lat);
      checks++; if (lat !== 2) begin failures++; $display("FAIL add_latency got=%0d exp=2", lat); end
      checks++; if (sum8 !== 8'h81) begin failures++; $display("FAIL add_sum got=%h exp=81", sum8); end
      checks++; if ({cout8, ovf8} !== 2'b01) begin failures++; $display("FAIL add_flags got=%b%b exp=01", cout8, ovf8); end
      checks++; if (ir8 !== 1'b0 || busy8 !== 1'b1) begin failures++; $display("FAIL add_done_status got=ready %b busy %b exp=ready 0 busy 1", ir8, busy8); end
      release8();
      checks++; if (ir8 !== 1'b1 || ov8 !== 1'b0) begin failures++; $display("FAIL add_release got=ready %b valid %b exp=ready 1 valid 0", ir8, ov8); end

      op8(8'hFF, 8'h01, 1'b0, 1'b0, lat);
      checks++; if (sum8 !== 8'h00) begin failures++; $display("FAIL carry_cross_sum got=%h exp=00", sum8); end
      checks++; if ({cout8, ovf8} !== 2'b10) begin failures++; $display("FAIL carry_cross_flags got=%b%b exp=10", cout8, ovf8); end
      release8();

      op8(8'h7F, 8'h01, 1'b1, 1'b0, lat);
      checks++; if ({sum8, cout8, ovf8} !== {8'h81, 2'b01}) begin failures++; $display("FAIL add_cin got=%h/%b%b exp=81/01", sum8, cout8, ovf8); end
      release8();
   endtask

   task automatic test_sub();
      int lat;
      op8(8'h10, 8'h20, 1'b1, 1'b1, lat);
      checks++; if (sum8 !== 8'hF0) begin failures++; $display("FAIL sub_borrow_sum got=%h exp=f0", sum8); end
      checks++; if ({cout8, ovf8} !== 2'b00) begin failures++; $display("FAIL sub_borrow_flags got=%b%b exp=00", cout8, ovf8); end
      release8();

      op8(8'h80, 8'h01, 1'b1, 1'b1, lat);
      checks++; if (sum8 !== 8'h7F) begin failures++; $display("FAIL sub_ovf_sum got=%h exp=7f", sum8); end
      checks++; if ({cout8, ovf8} !== 2'b11) begin failures++; $display("FAIL sub_ovf_flags got=%b%b exp=11", cout8, ovf8); end
      release8();

      op8(8'h55, 8'h55, 1'b1, 1'b1, lat);
      checks++; if ({sum8, cout8, ovf8} !== {8'h00, 2'b10}) begin failures++; $display("FAIL sub_equal got=%h/%b%b exp=00/10", sum8, cout8, ovf8); end
      release8();
   endtask

   task automatic test_backpressure();
      int lat;
      op8(8'h12, 8'h34, 1'b0, 1'b0, lat);
      checks++; if (sum8 !== 8'h46) begin failures++; $display("FAIL bp_sum got=%h exp=46", sum8); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         iv8 = (i == 2); a8 = 8'hAA; b8 = 8'hAA;
         @(posedge clk);
         #1;
         checks++;
         if (ov8 !== 1'b1 || ir8 !== 1'b0 || busy8 !== 1'b1 || sum8 !== 8'h46 || cout8 !== 1'b0 || ovf8 !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold cycle=%0d got=valid %b ready %b busy %b sum %h c %b v %b exp=1 0 1 46 0 0",
                     i, ov8, ir8, busy8, sum8, cout8, ovf8);
         end
      end
      iv8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
      release8();
      checks++; if (ir8 !== 1'b1 || ov8 !== 1'b0 || busy8 !== 1'b0) begin failures++; $display("FAIL bp_release got=ready %b valid %b busy %b exp=1 0 0", ir8, ov8, busy8); end
      // The pulse seen while DONE must not have started a new operation.
      repeat (3) @(posedge clk);
      #1;
      checks++; if (ov8 !== 1'b0 || ir8 !== 1'b1) begin failures++; $display("FAIL bp_ignored got=valid %b ready %b exp=0 1", ov8, ir8); end
   endtask

   task automatic test_async_reset();
      int lat;
      @(negedge clk);
      a8 = 8'hAA; b8 = 8'h55; iv8 = 1'b1;
      @(posedge clk);
      #1;
      iv8 = 1'b0;
      checks++; if (busy8 !== 1'b1) begin failures++; $display("FAIL rst_pre_busy got=%b exp=1", busy8); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (ov8 !== 1'b0 || busy8 !== 1'b0 || sum8 !== 8'h00 || ir8 !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid_run got=valid %b busy %b sum %h ready %b exp=0 0 00 1", ov8, busy8, sum8, ir8);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (ov8 !== 1'b0) begin failures++; $display("FAIL rst_aborted got=%b exp=0", ov8); end
      op8(8'h01, 8'h01, 1'b0, 1'b0, lat);
      checks++; if (sum8 !== 8'h02 || lat !== 2) begin failures++; $display("FAIL rst_recover got=%h lat %0d exp=02 lat 2", sum8, lat); end
      release8();
   endtask

   // Same operands to both 32-bit instances; measure each latency separately.
   task automatic test_wide();
      logic [31:0] av [3];
      logic [31:0] bv [3];
      logic        cv [3];
      logic        sv [3];
      logic [33:0] ev [3];
      int latn, latw, t;
      av[0] = 32'h7FFFFFFF; bv[0] = 32'h00000001; cv[0] = 1'b0; sv[0] = 1'b0; ev[0] = {32'h80000000, 2'b01};
      av[1] = 32'hFFFFFFFF; bv[1] = 32'h00000001; cv[1] = 1'b1; sv[1] = 1'b0; ev[1] = {32'h00000001, 2'b10};
      av[2] = 32'h00000000; bv[2] = 32'h00000001; cv[2] = 1'b1; sv[2] = 1'b1; ev[2] = {32'hFFFFFFFF, 2'b00};
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         a32 = av[k]; b32 = bv[k]; cin32 = cv[k]; sub32 = sv[k]; iv32 = 1'b1;
         @(posedge clk);
         #1;
         iv32 = 1'b0;
         latn = 0; latw = 0; t = 0;
         while (t < 40 && (latn == 0 || latw == 0)) begin
            @(posedge clk);
            #1;
            t = t + 1;
            if (ovn && latn == 0) latn = t;
            if (ovw && latw == 0) latw = t;
         end
         checks++; if (latn !== 8) begin failures++; $display("FAIL wide_g4_latency vec=%0d got=%0d exp=8", k, latn); end
         checks++; if (latw !== 1) begin failures++; $display("FAIL wide_g32_latency vec=%0d got=%0d exp=1", k, latw); end
         checks++; if ({sumn, coutn, ovfn} !== ev[k]) begin failures++; $display("FAIL wide_g4_result vec=%0d got=%h/%b%b exp=%h", k, sumn, coutn, ovfn, ev[k]); end
         checks++; if ({sumw, coutw, ovfw} !== ev[k]) begin failures++; $display("FAIL wide_g32_result vec=%0d got=%h/%b%b exp=%h", k, sumw, coutw, ovfw, ev[k]); end
         @(negedge clk);
         or32 = 1'b1;
         @(posedge clk);
         #1;
         or32 = 1'b0;
         checks++; if (irn !== 1'b1 || irw !== 1'b1 || busyn !== 1'b0 || busyw !== 1'b0) begin
            failures++;
            $display("FAIL wide_release vec=%0d got=ready %b%b busy %b%b exp=11 00", k, irn, irw, busyn, busyw);
         end
      end
   endtask

   initial begin
      checks = 0; failures = 0;
      rst_n = 1'b0;
      iv8 = 1'b0; or8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; sub8 = 1'b0;
      iv32 = 1'b0; or32 = 1'b0; a32 = 32'h0; b32 = 32'h0; cin32 = 1'b0; sub32 = 1'b0;
      #12;
      test_reset();
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_add();
      test_sub();
      test_backpressure();
      test_async_reset();
      test_wide();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
